mpu_elementwise: RTL and testbench

Sequential, parametrised element-wise matrix unit for the MPU datapath, and the successor of the single-cycle 5x5 8-bit adder. It captures two flattened DIM x DIM matrices on a start handshake and processes LANES elements per clock. It supports add, subtract, Hadamard multiply and scalar multiply, each with wrap or saturate arithmetic. The result is held in a register and a one-cycle done pulse is issued. It sits between the matrix register file and the MPU result bus.

---
 rtl/mpu_elementwise_if.sv | 36 +++
 rtl/mpu_elementwise.sv | 169 ++++++++++++++++
 tb/tb_mpu_elementwise.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_elementwise_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mpu_elementwise_if
//  Description : Request/result bundle between the matrix register file and
//                the element-wise matrix unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface mpu_elementwise_if #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8
);
  logic                       start;
  logic [1:0]                 op;
  logic                       saturate;
  logic [WIDTH-1:0]           scalar;
  logic [WIDTH*DIM*DIM-1:0]   matrix_a;
  logic [WIDTH*DIM*DIM-1:0]   matrix_b;
  logic [WIDTH*DIM*DIM-1:0]   result;
  logic                       busy;
  logic                       done;
  logic                       overflow;

  // Requester side: issues operations and consumes results
  modport master (
    output start, op, saturate, scalar, matrix_a, matrix_b,
    input  result, busy, done, overflow
  );

  // Unit side
  modport slave (
    input  start, op, saturate, scalar, matrix_a, matrix_b,
    output result, busy, done, overflow
  );
endinterface
`default_nettype wire

// File: rtl/mpu_elementwise.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mpu_elementwise
//  Description : Sequential element-wise matrix unit. Captures two DIM x DIM
//                matrices on start, processes LANES elements per clock
//                (add / sub / Hadamard mul / scalar mul, wrap or saturate),
//                holds the result and pulses done.
//  Revision    : 1.0  initial release
// ============================================================================
module mpu_elementwise #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8,
  parameter int LANES = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mpu_elementwise_if.slave     bus
);

  localparam int c_nelem = DIM * DIM;
  localparam int c_flat  = WIDTH * c_nelem;
  localparam int c_beats = (c_nelem + LANES - 1) / LANES;
  localparam int c_bw    = $clog2(c_beats + 1);
  localparam int c_iw    = $clog2(c_nelem);

  localparam logic [1:0] c_op_add  = 2'b00;
  localparam logic [1:0] c_op_sub  = 2'b01;
  localparam logic [1:0] c_op_hmul = 2'b10;

  localparam logic [c_bw-1:0]  c_last_beat = c_bw'(c_beats - 1);
  localparam logic [WIDTH-1:0] c_max_val   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_bw-1:0]     r_beat;
  logic [c_flat-1:0]   r_a;
  logic [c_flat-1:0]   r_b;
  logic [1:0]          r_op;
  logic                r_sat;
  logic [WIDTH-1:0]    r_scalar;
  logic [c_flat-1:0]   r_result;
  logic                r_ovf;

  logic                w_accept;
  logic [LANES-1:0]    w_act_vec;
  logic [LANES-1:0]    w_ovf_vec;
  logic [WIDTH-1:0]    w_val_arr [LANES];
  logic [c_iw-1:0]     w_idx_arr [LANES];

  // A new operation is taken whenever the unit is not mid-run
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // One arithmetic lane per processed element of the current beat
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int                 w_k;
    logic               w_act;
    logic [c_iw-1:0]    w_idx;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_m;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_val;
    logic               w_ovf;

    assign w_k    = int'(r_beat) * LANES + l;
    assign w_act  = (w_k < c_nelem);
    // Inactive lanes point at element 0 so the operand read stays in range
    assign w_idx  = w_act ? c_iw'(w_k) : '0;
    assign w_a    = r_a[WIDTH*int'(w_idx) +: WIDTH];
    assign w_b    = r_b[WIDTH*int'(w_idx) +: WIDTH];
    assign w_m    = (r_op == c_op_hmul) ? w_b : r_scalar;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_dif  = {1'b0, w_a} - {1'b0, w_b};
    assign w_prod = w_a * w_m;

    // Select the operation result and its out-of-range flag, then clamp if asked
    always_comb begin
      w_val = '0;
      w_ovf = 1'b0;
      case (r_op)
        c_op_add: begin
          w_ovf = w_sum[WIDTH];
          w_val = (w_ovf && r_sat) ? c_max_val : w_sum[WIDTH-1:0];
        end
        c_op_sub: begin
          // Borrow out of the extended subtraction marks a < b
          w_ovf = w_dif[WIDTH];
          w_val = (w_ovf && r_sat) ? '0 : w_dif[WIDTH-1:0];
        end
        default: begin
          w_ovf = |w_prod[2*WIDTH-1:WIDTH];
          w_val = (w_ovf && r_sat) ? c_max_val : w_prod[WIDTH-1:0];
        end
      endcase
    end

    assign w_act_vec[l] = w_act;
    assign w_ovf_vec[l] = w_act && w_ovf;
    assign w_val_arr[l] = w_val;
    assign w_idx_arr[l] = w_idx;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: RUN for exactly c_beats cycles, DONE for one
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (r_beat == c_last_beat) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on accept, lane write-back and overflow accumulation in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_sat    <= 1'b0;
      r_scalar <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_beat   <= '0;
      r_a      <= bus.matrix_a;
      r_b      <= bus.matrix_b;
      r_op     <= bus.op;
      r_sat    <= bus.saturate;
      r_scalar <= bus.scalar;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (r_state == S_RUN) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_act_vec[l]) begin
          r_result[WIDTH*int'(w_idx_arr[l]) +: WIDTH] <= w_val_arr[l];
        end
      end
      r_ovf  <= r_ovf | (|w_ovf_vec);
      r_beat <= r_beat + c_bw'(1);
    end
  end

  assign bus.result   = r_result;
  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mpu_elementwise.sv
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mpu_elementwise
//  Description : Scoreboard bench for mpu_elementwise (LANES=5 and LANES=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mpu_elementwise;

  localparam int DIM  = 5;
  localparam int W    = 8;
  localparam int N    = DIM * DIM;
  localparam int FLAT = W * N;

  typedef struct {
    string           name;
    logic [FLAT-1:0] res;
    logic            ovf;
    int              lat;
    int              t0;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q5[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  mpu_elementwise_if #(.DIM(DIM), .WIDTH(W)) b5 ();
  mpu_elementwise_if #(.DIM(DIM), .WIDTH(W)) b4 ();

  mpu_elementwise #(.DIM(DIM), .WIDTH(W), .LANES(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b5)
  );

  mpu_elementwise #(.DIM(DIM), .WIDTH(W), .LANES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [FLAT-1:0] ramp(input int s, input int step);
    logic [FLAT-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < N; k++) begin
      v = s + step * k;
      r[W*k +: W] = v[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [FLAT-1:0] fill(input int c);
    return ramp(c, 0);
  endfunction

  function automatic exp_t mkexp(input string nm, input logic [FLAT-1:0] res,
                                 input logic ovf, input int lat);
    exp_t e;
    e.name = nm;
    e.res  = res;
    e.ovf  = ovf;
    e.lat  = lat;
    e.t0   = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [FLAT-1:0] act, input logic [FLAT-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic score(input exp_t e, input logic [FLAT-1:0] res, input logic ovf);
    chk({e.name, "_result"}, res, e.res);
    chk({e.name, "_overflow"}, {{(FLAT-1){1'b0}}, ovf}, {{(FLAT-1){1'b0}}, e.ovf});
    chk({e.name, "_latency"}, FLAT'(cyc - e.t0), FLAT'(e.lat));
  endtask

  // Monitors: compare every done pulse against the oldest expectation
  initial forever begin
    @(negedge clk);
    if (rst_n && b5.done) begin
      if (q5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done5 actual=1 required=0");
      end else begin
        score(q5.pop_front(), b5.result, b5.overflow);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && b4.done) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done4 actual=1 required=0");
      end else begin
        score(q4.pop_front(), b4.result, b4.overflow);
      end
    end
  end

  task automatic drive5(input logic [1:0] op, input logic sat, input logic [W-1:0] sc,
                        input logic [FLAT-1:0] a, input logic [FLAT-1:0] b);
    @(negedge clk);
    b5.op       = op;
    b5.saturate = sat;
    b5.scalar   = sc;
    b5.matrix_a = a;
    b5.matrix_b = b;
    b5.start    = 1'b1;
  endtask

  task automatic accept5(input exp_t e);
    @(posedge clk);
    #1;
    e.t0 = cyc;
    q5.push_back(e);
    b5.start = 1'b0;
  endtask

  task automatic wait5();
    int n = 0;
    while (q5.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q5.size() != 0) begin
      errors++;
      $display("FAIL drain5 actual=%0d required=0", q5.size());
      q5.delete();
    end
  endtask

  task automatic wait4();
    int n = 0;
    while (q4.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q4.size() != 0) begin
      errors++;
      $display("FAIL drain4 actual=%0d required=0", q4.size());
      q4.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    b5.start = 1'b0; b5.op = '0; b5.saturate = 1'b0; b5.scalar = '0;
    b5.matrix_a = '0; b5.matrix_b = '0;
    b4.start = 1'b0; b4.op = '0; b4.saturate = 1'b0; b4.scalar = '0;
    b4.matrix_a = '0; b4.matrix_b = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_result", b5.result, '0);
    chk("rst_busy", FLAT'(b5.busy), '0);
    chk("rst_done", FLAT'(b5.done), '0);
    chk("rst_overflow", FLAT'(b5.overflow), '0);
    rst_n = 1'b1;

    // Add: 1..25 + 25..1 = 26 everywhere, busy for the 5 run cycles
    drive5(2'b00, 1'b0, 8'd0, ramp(1, 1), ramp(25, -1));
    accept5(mkexp("add", fill(26), 1'b0, 5));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("add_busy", FLAT'(b5.busy), FLAT'(1));
    end
    wait5();
    @(negedge clk);
    chk("done_pulse_width", FLAT'(b5.done), '0);

    // Subtract with underflow, saturate and wrap
    drive5(2'b01, 1'b1, 8'd0, fill(3), fill(10));
    accept5(mkexp("sub_sat", fill(0), 1'b1, 5));
    wait5();
    drive5(2'b01, 1'b0, 8'd0, fill(3), fill(10));
    accept5(mkexp("sub_wrap", fill(249), 1'b1, 5));
    wait5();

    // Hadamard multiply 20*13 = 260
    drive5(2'b10, 1'b1, 8'd0, fill(20), fill(13));
    accept5(mkexp("mul_sat", fill(255), 1'b1, 5));
    wait5();
    drive5(2'b10, 1'b0, 8'd0, fill(20), fill(13));
    accept5(mkexp("mul_wrap", fill(4), 1'b1, 5));
    wait5();

    // Scalar multiply: B must be ignored
    drive5(2'b11, 1'b0, 8'd10, ramp(1, 1), fill(200));
    accept5(mkexp("scalar", ramp(10, 10), 1'b0, 5));
    wait5();

    // start during RUN is ignored
    drive5(2'b00, 1'b0, 8'd0, ramp(1, 1), ramp(25, -1));
    accept5(mkexp("run_start_ignored", fill(26), 1'b0, 5));
    @(negedge clk);
    @(negedge clk);
    b5.start = 1'b1; b5.op = 2'b01; b5.saturate = 1'b1;
    b5.matrix_a = fill(0); b5.matrix_b = fill(5);
    @(negedge clk);
    b5.start = 1'b0;
    wait5();
    repeat (3) @(negedge clk);
    chk("idle_hold_result", b5.result, fill(26));
    chk("idle_busy", FLAT'(b5.busy), '0);

    // Back-to-back: start held through done starts the next operation
    drive5(2'b00, 1'b0, 8'd0, fill(1), fill(2));
    accept5(mkexp("b2b_first", fill(3), 1'b0, 5));
    @(negedge clk);
    b5.start = 1'b1; b5.op = 2'b10; b5.saturate = 1'b0;
    b5.matrix_a = fill(7); b5.matrix_b = fill(6);
    n = 0;
    while (!b5.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!b5.done) begin
      errors++;
      $display("FAIL b2b_wait_done actual=0 required=1");
    end
    @(posedge clk);
    #1;
    chk("b2b_cleared", b5.result, '0);
    chk("b2b_busy", FLAT'(b5.busy), FLAT'(1));
    begin
      exp_t e2;
      e2 = mkexp("b2b_second", fill(42), 1'b0, 5);
      e2.t0 = cyc;
      q5.push_back(e2);
    end
    b5.start = 1'b0;
    wait5();

    // Asynchronous reset in the middle of a run
    drive5(2'b10, 1'b0, 8'd0, fill(20), fill(13));
    @(posedge clk);
    #1;
    b5.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_overflow", FLAT'(b5.overflow), FLAT'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", FLAT'(b5.busy), '0);
    chk("async_rst_done", FLAT'(b5.done), '0);
    chk("async_rst_overflow", FLAT'(b5.overflow), '0);
    chk("async_rst_result", b5.result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive5(2'b00, 1'b0, 8'd0, ramp(1, 1), ramp(25, -1));
    accept5(mkexp("post_reset_add", fill(26), 1'b0, 5));
    wait5();

    // Partial last beat with LANES=4: 7 beats
    @(negedge clk);
    b4.op = 2'b00; b4.saturate = 1'b0; b4.scalar = '0;
    b4.matrix_a = ramp(1, 1); b4.matrix_b = ramp(25, -1);
    b4.start = 1'b1;
    @(posedge clk);
    #1;
    begin
      exp_t e4;
      e4 = mkexp("lanes4_add", fill(26), 1'b0, 7);
      e4.t0 = cyc;
      q4.push_back(e4);
    end
    b4.start = 1'b0;
    wait4();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
